// File: rtl/ctrl_pipe.sv
// Control-only pipeline ID/EX -> EX/MEM -> MEM/WB with branch/jump resolution in Execute.
// Latency: D-stage controls reach E outputs after 1 edge, M after 2, W after 3; PCSrcE/FlushD are combinational.
// Backpressure: none; every stage advances each edge, Decode stalls are handled upstream by holding the D inputs.
module ctrl_pipe #(
  parameter int RES_W  = 2,
  parameter int ALUC_W = 3,
  parameter int IMM_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteD,
  input  logic [RES_W-1:0]  ResultSrcD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic              ALUSrcAD,
  input  logic              ALUSrcBD,
  input  logic              LdSrcD,
  input  logic              StSrcD,
  input  logic              JalSrcD,
  input  logic [2:0]        funct3D,
  input  logic              FlushE,
  input  logic              ZeroE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              ALUSrcAE,
  output logic              ALUSrcBE,
  output logic              PCSrcE,
  output logic              FlushD,
  output logic              RegWriteE,
  output logic [RES_W-1:0]  ResultSrcE,
  output logic              MemWriteM,
  output logic              StSrcM,
  output logic              RegWriteM,
  output logic [RES_W-1:0]  ResultSrcM,
  output logic              RegWriteW,
  output logic [RES_W-1:0]  ResultSrcW,
  output logic              LdSrcW,
  output logic              JalSrcW,
  output logic              ValidE,
  output logic              ValidM,
  output logic              ValidW
);

  // ImmSrc is decoded upstream and never carried here; its width is only sanity-checked.
  if (IMM_W != 3) begin : g_imm_w_check
    $error("ctrl_pipe: ImmSrc width must be 3");
  end

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [RES_W-1:0]  resultsrc;
    logic              memwrite;
    logic              jump;
    logic              branch;
    logic [ALUC_W-1:0] aluctrl;
    logic              alusrca;
    logic              alusrcb;
    logic              ldsrc;
    logic              stsrc;
    logic              jalsrc;
    logic [2:0]        funct3;
  } ctrl_e_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [RES_W-1:0]  resultsrc;
    logic              memwrite;
    logic              stsrc;
    logic              ldsrc;
    logic              jalsrc;
  } ctrl_m_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [RES_W-1:0]  resultsrc;
    logic              ldsrc;
    logic              jalsrc;
  } ctrl_w_t;

  ctrl_e_t e_q, e_next;
  ctrl_m_t m_q;
  ctrl_w_t w_q;
  logic    taken;
  logic    bubble;

  // Branch condition from funct3; blt relies on the ALU doing SLT so Zero=0 means "less than".
  always_comb begin
    taken = 1'b0;
    case (e_q.funct3)
      3'b000:  taken = ZeroE;
      3'b001:  taken = ~ZeroE;
      3'b100:  taken = ~ZeroE;
      3'b101:  taken = ZeroE;
      default: taken = 1'b0;
    endcase
  end

  assign PCSrcE = e_q.valid & (e_q.jump | (e_q.branch & taken));
  assign FlushD = PCSrcE;
  assign bubble = FlushE | PCSrcE;

  // Next E contents: a hazard bubble or the instruction behind a taken transfer becomes all zeros.
  always_comb begin
    e_next = '0;
    if (!bubble) begin
      e_next.valid     = 1'b1;
      e_next.regwrite  = RegWriteD;
      e_next.resultsrc = ResultSrcD;
      e_next.memwrite  = MemWriteD;
      e_next.jump      = JumpD;
      e_next.branch    = BranchD;
      e_next.aluctrl   = ALUControlD;
      e_next.alusrca   = ALUSrcAD;
      e_next.alusrcb   = ALUSrcBD;
      e_next.ldsrc     = LdSrcD;
      e_next.stsrc     = StSrcD;
      e_next.jalsrc    = JalSrcD;
      e_next.funct3    = funct3D;
    end
  end

  // Stage registers: E loads the (possibly bubbled) decode controls, M and W copy unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_next;
      m_q <= '{valid:     e_q.valid,
               regwrite:  e_q.regwrite,
               resultsrc: e_q.resultsrc,
               memwrite:  e_q.memwrite,
               stsrc:     e_q.stsrc,
               ldsrc:     e_q.ldsrc,
               jalsrc:    e_q.jalsrc};
      w_q <= '{valid:     m_q.valid,
               regwrite:  m_q.regwrite,
               resultsrc: m_q.resultsrc,
               ldsrc:     m_q.ldsrc,
               jalsrc:    m_q.jalsrc};
    end
  end

  assign ALUControlE = e_q.aluctrl;
  assign ALUSrcAE    = e_q.alusrca;
  assign ALUSrcBE    = e_q.alusrcb;
  assign RegWriteE   = e_q.regwrite;
  assign ResultSrcE  = e_q.resultsrc;
  assign ValidE      = e_q.valid;
  assign MemWriteM   = m_q.memwrite;
  assign StSrcM      = m_q.stsrc;
  assign RegWriteM   = m_q.regwrite;
  assign ResultSrcM  = m_q.resultsrc;
  assign ValidM      = m_q.valid;
  assign RegWriteW   = w_q.regwrite;
  assign ResultSrcW  = w_q.resultsrc;
  assign LdSrcW      = w_q.ldsrc;
  assign JalSrcW     = w_q.jalsrc;
  assign ValidW      = w_q.valid;

endmodule
